pipeline_hazard_ctrl: RTL and testbench

//   Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_hazard_ctrl_if.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the pipeline and per-stage stall/flush controls back to it.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
    logic                  id_uses_rs2, ex_memread, ex_branch_taken, mem_req, mem_ready;
    logic                  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_hold;
    logic                  mem_timeout;
    logic [1:0]            state_o;
    logic [CNT_W-1:0]      stall_cycles, flush_events;
    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd, ex_branch_taken, mem_req, mem_ready,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_hold,
        input  mem_timeout, state_o, stall_cycles, flush_events
    );
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd, ex_branch_taken, mem_req, mem_ready,
        output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_hold,
        output mem_timeout, state_o, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, taken-branch flush and memory-wait freeze sequencer.
// HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 16
) (
    input logic clk,
    input logic reset,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} state_t;
    state_t          state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [2:0]      fl_q, fl_d;
    logic            mem_timeout_q, mem_timeout_d;
    logic            load_use, stall_req, apply_rules;
    always_comb begin
        load_use = hz.ex_memread && hz.ex_rd != {REG_ADDR_W{1'b0}} &&
                   (hz.ex_rd == hz.id_rs1 || (hz.id_uses_rs2 && hz.ex_rd == hz.id_rs2));
        stall_req = hz.mem_req && !hz.mem_ready;
        hz.pc_write = 1'b1;
        hz.ifid_write = 1'b1;
        hz.idex_bubble = 1'b0;
        hz.ifid_flush = 1'b0;
        hz.idex_flush = 1'b0;
        hz.exmem_hold = 1'b0;
        state_d = state_q;
        wait_d = wait_q;
        fl_d = fl_q;
        mem_timeout_d = mem_timeout_q;
        apply_rules = 1'b0;
        case (state_q)
            RUN: begin
                if (stall_req) begin
                    hz.pc_write = 1'b0;
                    hz.ifid_write = 1'b0;
                    hz.exmem_hold = 1'b1;
                    wait_d = WW'(1);
                    state_d = MEM_WAIT;
                end else apply_rules = 1'b1;
            end
            MEM_WAIT: begin
                if (hz.mem_ready) begin
                    state_d = RUN;
                    apply_rules = 1'b1;
                end else if (wait_q < WW'(MEM_TIMEOUT)) begin
                    hz.pc_write = 1'b0;
                    hz.ifid_write = 1'b0;
                    hz.exmem_hold = 1'b1;
                    wait_d = wait_q + 1'b1;
                end else begin
                    mem_timeout_d = 1'b1;
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (stall_req) begin
                    hz.pc_write = 1'b0;
                    hz.ifid_write = 1'b0;
                    hz.exmem_hold = 1'b1;
                end else begin
                    hz.ifid_flush = 1'b1;
                    fl_d = fl_q - 3'd1;
                    state_d = (fl_q <= 3'd1) ? RUN : FLUSH;
                end
            end
            default: state_d = RUN;
        endcase
        // A taken branch squashes the ID instruction, so it overrides any load-use bubble
        if (apply_rules && hz.ex_branch_taken) begin
            hz.ifid_flush = 1'b1;
            hz.idex_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                fl_d = 3'(FLUSH_CYCLES - 1);
                state_d = FLUSH;
            end
        end else if (apply_rules && load_use) begin
            hz.pc_write = 1'b0;
            hz.ifid_write = 1'b0;
            hz.idex_bubble = 1'b1;
        end
        if (reset) begin
            hz.pc_write = 1'b0;
            hz.ifid_write = 1'b0;
            hz.idex_bubble = 1'b0;
            hz.exmem_hold = 1'b0;
            hz.ifid_flush = 1'b1;
            hz.idex_flush = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            wait_q <= '0;
            fl_q <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q <= wait_d;
            fl_q <= fl_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end
    assign hz.state_o = state_q;
    assign hz.mem_timeout = mem_timeout_q;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d, flev_q, flev_d;
    logic             flush_evt;
    assign flush_evt = apply_rules && hz.ex_branch_taken;
    always_comb begin
        stall_d = (!hz.pc_write && stall_q != {CNT_W{1'b1}}) ? stall_q + 1'b1 : stall_q;
        flev_d = (flush_evt && flev_q != {CNT_W{1'b1}}) ? flev_q + 1'b1 : flev_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flev_q <= '0;
        end else begin
            stall_q <= stall_d;
            flev_q <= flev_d;
        end
    end
    assign hz.stall_cycles = stall_q;
    assign hz.flush_events = flev_q;
`else
    assign hz.stall_cycles = {CNT_W{1'b0}};
    assign hz.flush_events = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of stall/flush sequencing with FLUSH_CYCLES=2.
module tb_pipeline_hazard_ctrl;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;
    int sc_exp = 0;
    int fe_exp = 0;
    logic [5:0] ctrl;
    pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) hz ();
    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(2), .MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .hz(hz.slave)
    );
    always #5 clk = ~clk;
    // {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_hold}
    assign ctrl = {hz.pc_write, hz.ifid_write, hz.idex_bubble, hz.ifid_flush, hz.idex_flush, hz.exmem_hold};
    task automatic idle();
        hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_uses_rs2 = 0; hz.ex_memread = 0;
        hz.ex_rd = '0; hz.ex_branch_taken = 0; hz.mem_req = 0; hz.mem_ready = 0;
    endtask
    task automatic next();
        @(posedge clk); #1;
    endtask
    task automatic expect_cycle(input string name, input logic [5:0] exp_ctrl, input logic [1:0] exp_st);
        @(negedge clk);
        checks++;
        if (ctrl !== exp_ctrl) begin
            $display("FAIL %s ctrl got=%b exp=%b", name, ctrl, exp_ctrl); failures++;
        end
        checks++;
        if (hz.state_o !== exp_st) begin
            $display("FAIL %s state got=%0d exp=%0d", name, hz.state_o, exp_st); failures++;
        end
        next();
    endtask
    task automatic check_counters(input string name);
        logic [15:0] es, ef;
        es = PERF ? 16'(sc_exp) : 16'd0;
        ef = PERF ? 16'(fe_exp) : 16'd0;
        @(negedge clk);
        checks++;
        if (hz.stall_cycles !== es) begin
            $display("FAIL %s stall_cycles got=%0d exp=%0d", name, hz.stall_cycles, es); failures++;
        end
        checks++;
        if (hz.flush_events !== ef) begin
            $display("FAIL %s flush_events got=%0d exp=%0d", name, hz.flush_events, ef); failures++;
        end
        next();
    endtask
    task automatic test_reset();
        reset = 1; idle(); next();
        for (int i = 0; i < 3; i++) expect_cycle("reset", 6'b000110, 2'd0);
        reset = 0;
        @(negedge clk);
        checks++;
        if (hz.mem_timeout !== 1'b0) begin
            $display("FAIL reset mem_timeout got=%b exp=0", hz.mem_timeout); failures++;
        end
        next();
        sc_exp = 0; fe_exp = 0;
        expect_cycle("reset_release", 6'b110000, 2'd0);
        check_counters("reset_cnt");
    endtask
    task automatic test_load_use();
        hz.ex_memread = 1; hz.ex_rd = 5'd3; hz.id_rs1 = 5'd3;
        expect_cycle("lu_rs1", 6'b001000, 2'd0); sc_exp++;
        idle();
        expect_cycle("lu_after", 6'b110000, 2'd0);
        hz.ex_memread = 1; hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0;
        expect_cycle("lu_x0", 6'b110000, 2'd0);
        hz.ex_rd = 5'd7; hz.id_rs1 = 5'd1; hz.id_rs2 = 5'd7; hz.id_uses_rs2 = 1;
        expect_cycle("lu_rs2", 6'b001000, 2'd0); sc_exp++;
        hz.id_uses_rs2 = 0;
        expect_cycle("lu_rs2_unused", 6'b110000, 2'd0);
        hz.ex_memread = 0; hz.id_rs1 = 5'd7;
        expect_cycle("lu_not_load", 6'b110000, 2'd0);
        idle();
        check_counters("lu_cnt");
    endtask
    task automatic test_branch();
        hz.ex_branch_taken = 1;
        expect_cycle("br_c0", 6'b110110, 2'd0); fe_exp++;
        idle();
        expect_cycle("br_c1", 6'b110100, 2'd2);
        expect_cycle("br_c2", 6'b110000, 2'd0);
        check_counters("br_cnt");
    endtask
    task automatic test_mem_wait();
        hz.mem_req = 1; hz.mem_ready = 0;
        expect_cycle("mw_c0", 6'b000001, 2'd0);
        for (int i = 0; i < 3; i++) expect_cycle("mw_wait", 6'b000001, 2'd1);
        sc_exp += 4;
        hz.mem_ready = 1;
        expect_cycle("mw_ready", 6'b110000, 2'd1);
        idle();
        expect_cycle("mw_back", 6'b110000, 2'd0);
        check_counters("mw_cnt");
    endtask
    task automatic test_back_to_back();
        hz.mem_req = 1; hz.mem_ready = 0;
        expect_cycle("bb_freeze", 6'b000001, 2'd0); sc_exp++;
        hz.mem_ready = 1; hz.ex_branch_taken = 1;
        expect_cycle("bb_ready_br", 6'b110110, 2'd1); fe_exp++;
        hz.mem_ready = 0; hz.ex_branch_taken = 1;
        expect_cycle("bb_flush_freeze", 6'b000001, 2'd2); sc_exp++;
        hz.mem_req = 0;
        expect_cycle("bb_flush_go", 6'b110100, 2'd2);
        idle();
        expect_cycle("bb_run", 6'b110000, 2'd0);
        check_counters("bb_cnt");
    endtask
    task automatic test_timeout();
        hz.mem_req = 1; hz.mem_ready = 0;
        expect_cycle("to_c0", 6'b000001, 2'd0);
        for (int i = 1; i < 16; i++) expect_cycle("to_wait", 6'b000001, 2'd1);
        sc_exp += 16;
        checks++;
        if (hz.mem_timeout !== 1'b0) begin
            $display("FAIL to_early mem_timeout got=%b exp=0", hz.mem_timeout); failures++;
        end
        expect_cycle("to_release", 6'b110000, 2'd1);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (hz.mem_timeout !== 1'b1 || hz.state_o !== 2'd0) begin
                $display("FAIL to_sticky mem_timeout got=%b state=%0d exp=1/0", hz.mem_timeout, hz.state_o);
                failures++;
            end
            next();
        end
        check_counters("to_cnt");
        reset = 1; next(); reset = 0;
        sc_exp = 0; fe_exp = 0;
        @(negedge clk);
        checks++;
        if (hz.mem_timeout !== 1'b0) begin
            $display("FAIL to_reset mem_timeout got=%b exp=0", hz.mem_timeout); failures++;
        end
        next();
    endtask
    task automatic test_branch_load_use();
        hz.ex_branch_taken = 1; hz.ex_memread = 1; hz.ex_rd = 5'd5; hz.id_rs1 = 5'd5;
        expect_cycle("bl_c0", 6'b110110, 2'd0); fe_exp++;
        idle();
        check_counters("bl_cnt");
        expect_cycle("bl_run", 6'b110000, 2'd0);
    endtask
    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_back_to_back();
        test_timeout();
        test_branch_load_use();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
